load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-request RV32I load/store engine between a pipeline and a data memory.
//   A request is accepted in IDLE, performs its memory access in ACCESS (and, for a
//   store straddling a word boundary, a second write in ACCESS2), then returns a
//   one-cycle response in RESP.
//
//   Build option: define LSU_MISALIGN_EN to support any alignment (crossing stores
//   are split over two word writes). When undefined, a halfword at an odd address or
//   a word not on a word boundary completes with resp_err_o=1 and no write.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 request handshake (valid/ready), we, funct3, addr, wdata, rd tag
//   resp_*                completion pulse, load data, rd tag, error flag
//   DMemRAddr_o/RData_i   word-aligned read address, combinational 64-bit read data
//   DMemW*_o              word-aligned write address, data and byte mask
module load_store_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [4:0]  req_rd_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic [4:0]  resp_rd_o,
   output logic        resp_err_o,
   output logic [31:0] DMemRAddr_o,
   input  logic [63:0] DMemRData_i,
   output logic [31:0] DMemWAddr_o,
   output logic [63:0] DMemWData_o,
   output logic [4:0]  DMemWMask_o
);

   typedef enum logic [1:0] {StIdle, StAccess, StAccess2, StResp} state_e;

   state_e      r_state;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [4:0]  r_rd;
   logic        r_resp_valid;
   logic [31:0] r_resp_data;
   logic [4:0]  r_resp_rd;
   logic        r_resp_err;

   logic [1:0]  w_off;
   logic [31:0] w_aligned;
   logic [3:0]  w_bytemask;
   logic        w_illegal;
   logic        w_misalign;
   logic        w_cross;
   logic        w_err;
   logic [7:0]  w_mask8;
   logic [63:0] w_wdata_sh;
   logic [31:0] w_rdata_sh;
   logic [31:0] w_load_data;

   assign w_off     = r_addr[1:0];
   assign w_aligned = {r_addr[31:2], 2'b00};

   always_comb begin
      w_bytemask = 4'b1111;
      case (r_funct3[1:0])
         2'b00:   w_bytemask = 4'b0001;
         2'b01:   w_bytemask = 4'b0011;
         default: w_bytemask = 4'b1111;
      endcase
   end

   // Loads allow 000/001/010/100/101; stores allow only 000/001/010.
   assign w_illegal = r_we ? (r_funct3 > 3'b010)
                           : ((r_funct3 == 3'b011) || (r_funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_EN
   logic [2:0] w_size;
   assign w_size     = (r_funct3[1:0] == 2'b00) ? 3'd1 :
                       (r_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
   assign w_misalign = 1'b0;
   assign w_cross    = r_we && (({1'b0, w_off} + w_size) > 3'd4);
`else
   assign w_misalign = ((r_funct3[1:0] == 2'b01) && w_off[0]) ||
                       ((r_funct3[1:0] == 2'b10) && (w_off != 2'b00));
   assign w_cross    = 1'b0;
`endif

   assign w_err = w_illegal || w_misalign;

   // Low nibble/word feed the first write, high nibble/word the second (crossing) write.
   assign w_mask8    = {4'b0000, w_bytemask} << w_off;
   assign w_wdata_sh = {32'h0, r_wdata} << {w_off, 3'b000};
   assign w_rdata_sh = 32'(DMemRData_i >> {w_off, 3'b000});

   always_comb begin
      w_load_data = '0;
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_rdata_sh[7]}}, w_rdata_sh[7:0]};
         3'b001:  w_load_data = {{16{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
         3'b010:  w_load_data = w_rdata_sh;
         3'b100:  w_load_data = {24'h0, w_rdata_sh[7:0]};
         3'b101:  w_load_data = {16'h0, w_rdata_sh[15:0]};
         default: w_load_data = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= StIdle;
         r_we         <= 1'b0;
         r_funct3     <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rd         <= '0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_rd    <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (req_valid_i) begin
                  r_we     <= req_we_i;
                  r_funct3 <= req_funct3_i;
                  r_addr   <= req_addr_i;
                  r_wdata  <= req_wdata_i;
                  r_rd     <= req_rd_i;
                  r_state  <= StAccess;
               end
            end
            StAccess: begin
               r_resp_rd   <= r_rd;
               r_resp_err  <= w_err;
               r_resp_data <= (!r_we && !w_err) ? w_load_data : 32'h0;
               if (!w_err && w_cross) begin
                  r_state <= StAccess2;
               end else begin
                  r_state      <= StResp;
                  r_resp_valid <= 1'b1;
               end
            end
            StAccess2: begin
               r_state      <= StResp;
               r_resp_valid <= 1'b1;
            end
            StResp: begin
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Write port is driven only while a legal store is in a write state.
   always_comb begin
      DMemWAddr_o = '0;
      DMemWData_o = '0;
      DMemWMask_o = '0;
      if (r_state == StAccess && r_we && !w_err) begin
         DMemWAddr_o = w_aligned;
         DMemWData_o = {32'h0, w_wdata_sh[31:0]};
         DMemWMask_o = {1'b0, w_mask8[3:0]};
      end else if (r_state == StAccess2) begin
         DMemWAddr_o = w_aligned + 32'd4;
         DMemWData_o = {32'h0, w_wdata_sh[63:32]};
         DMemWMask_o = {1'b0, w_mask8[7:4]};
      end
   end

   assign DMemRAddr_o  = w_aligned;
   assign req_ready_o  = (r_state == StIdle);
   assign resp_valid_o = r_resp_valid;
   assign resp_data_o  = r_resp_data;
   assign resp_rd_o    = r_resp_rd;
   assign resp_err_o   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Expected responses go into a scoreboard
// queue when a request is driven; a monitor pops and compares them on resp_valid_o.
// Write-port behaviour is checked inline by each scenario task.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [2:0]  req_funct3_i = '0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic [4:0]  req_rd_i = '0;
   logic        resp_valid_o;
   logic [31:0] resp_data_o;
   logic [4:0]  resp_rd_o;
   logic        resp_err_o;
   logic [31:0] DMemRAddr_o;
   logic [63:0] DMemRData_i = '0;
   logic [31:0] DMemWAddr_o;
   logic [63:0] DMemWData_o;
   logic [4:0]  DMemWMask_o;

   load_store_unit dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_rd_i     (req_rd_i),
      .resp_valid_o (resp_valid_o),
      .resp_data_o  (resp_data_o),
      .resp_rd_o    (resp_rd_o),
      .resp_err_o   (resp_err_o),
      .DMemRAddr_o  (DMemRAddr_o),
      .DMemRData_i  (DMemRData_i),
      .DMemWAddr_o  (DMemWAddr_o),
      .DMemWData_o  (DMemWData_o),
      .DMemWMask_o  (DMemWMask_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic [4:0]  rd;
      int          lat;
      int          t0;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: latency is counted in rising edges from the accept edge to
   // the edge that consumes the response.
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (resp_valid_o === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL resp_unexpected: resp_valid_o=1 rd=%0d required no response", resp_rd_o);
         end else begin
            e   = exp_q.pop_front();
            lat = cyc - e.t0;
            if (resp_data_o !== e.data || resp_err_o !== e.err || resp_rd_o !== e.rd
                || lat != e.lat) begin
               n_errors++;
               $display("FAIL resp_rd%0d: data=%h err=%b rd=%0d lat=%0d required data=%h err=%b rd=%0d lat=%0d",
                        e.rd, resp_data_o, resp_err_o, resp_rd_o, lat, e.data, e.err, e.rd, e.lat);
            end
         end
         n_checks++;
         if (prev_valid === 1'b1) begin
            n_errors++;
            $display("FAIL resp_pulse: resp_valid_o high %0d cycles running, required 1", 2);
         end
      end
      prev_valid <= resp_valid_o;
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [63:0] rdata,
                        input logic [31:0] edata, input logic eerr, input int elat,
                        input bit push);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (req_ready_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (req_ready_o !== 1'b1) begin
         n_errors++;
         $display("FAIL ready_timeout: req_ready_o=%b required 1", req_ready_o);
         return;
      end
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wd;
      req_rd_i     = rd;
      DMemRData_i  = rdata;
      if (push) begin
         e.data = edata;
         e.err  = eerr;
         e.rd   = rd;
         e.lat  = elat;
         e.t0   = cyc;
         exp_q.push_back(e);
      end
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({req_ready_o, resp_valid_o, resp_err_o} !== 3'b100) begin
         n_errors++;
         $display("FAIL reset_flags: ready/valid/err=%b required 100",
                  {req_ready_o, resp_valid_o, resp_err_o});
      end
      n_checks++;
      if ({resp_data_o, resp_rd_o} !== 37'h0) begin
         n_errors++;
         $display("FAIL reset_resp: data=%h rd=%0d required 0/0", resp_data_o, resp_rd_o);
      end
      n_checks++;
      if ({DMemRAddr_o, DMemWAddr_o, DMemWData_o, DMemWMask_o} !== 133'h0) begin
         n_errors++;
         $display("FAIL reset_dmem: raddr=%h waddr=%h wdata=%h mask=%b required all 0",
                  DMemRAddr_o, DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_store_aligned();
      issue(1'b1, 3'b010, 32'h0001_0004, 32'hDEAD_BEEF, 5'd5, 64'h0, 32'h0, 1'b0, 2, 1'b1);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0001_0004, 64'hDEAD_BEEF, 5'b01111}) begin
         n_errors++;
         $display("FAIL sw_access: waddr=%h wdata=%h mask=%b required 00010004/00000000deadbeef/01111",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      n_checks++;
      if (req_ready_o !== 1'b0) begin
         n_errors++;
         $display("FAIL sw_busy: req_ready_o=%b required 0", req_ready_o);
      end
      @(negedge clk);
      n_checks++;
      if (DMemWMask_o !== 5'b0) begin
         n_errors++;
         $display("FAIL sw_resp_mask: mask=%b required 00000", DMemWMask_o);
      end
      // Byte and halfword stores: data shifted unmasked, mask covers the lanes.
      issue(1'b1, 3'b000, 32'h0001_0001, 32'h1234_56AB, 5'd6, 64'h0, 32'h0, 1'b0, 2, 1'b1);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0001_0000, 64'h3456_AB00, 5'b00010}) begin
         n_errors++;
         $display("FAIL sb_access: waddr=%h wdata=%h mask=%b required 00010000/3456ab00/00010",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      issue(1'b1, 3'b001, 32'h0001_0002, 32'h0000_BEEF, 5'd7, 64'h0, 32'h0, 1'b0, 2, 1'b1);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0001_0000, 64'hBEEF_0000, 5'b01100}) begin
         n_errors++;
         $display("FAIL sh_access: waddr=%h wdata=%h mask=%b required 00010000/beef0000/01100",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      wait_drain("store_aligned");
   endtask

   task automatic test_load_ext();
      logic [63:0] rd64 = 64'h0000_0000_80FF_1234;
      issue(1'b0, 3'b000, 32'h0001_0003, 32'h0, 5'd1, rd64, 32'hFFFF_FF80, 1'b0, 2, 1'b1);
      n_checks++;
      if ({DMemRAddr_o, DMemWMask_o} !== {32'h0001_0000, 5'b0}) begin
         n_errors++;
         $display("FAIL lb_access: raddr=%h mask=%b required 00010000/00000", DMemRAddr_o, DMemWMask_o);
      end
      issue(1'b0, 3'b100, 32'h0001_0003, 32'h0, 5'd2, rd64, 32'h0000_0080, 1'b0, 2, 1'b1);
      issue(1'b0, 3'b001, 32'h0001_0002, 32'h0, 5'd3, rd64, 32'hFFFF_80FF, 1'b0, 2, 1'b1);
      issue(1'b0, 3'b101, 32'h0001_0002, 32'h0, 5'd4, rd64, 32'h0000_80FF, 1'b0, 2, 1'b1);
      issue(1'b0, 3'b010, 32'h0001_0000, 32'h0, 5'd8, rd64, 32'h80FF_1234, 1'b0, 2, 1'b1);
      wait_drain("load_ext");
   endtask

   task automatic test_misalign();
      logic [63:0] rd64 = 64'h8877_6655_4433_2211;
`ifdef LSU_MISALIGN_EN
      issue(1'b1, 3'b010, 32'h0001_0006, 32'h1122_3344, 5'd9, 64'h0, 32'h0, 1'b0, 3, 1'b1);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0001_0004, 64'h3344_0000, 5'b01100}) begin
         n_errors++;
         $display("FAIL swx_access: waddr=%h wdata=%h mask=%b required 00010004/33440000/01100",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      @(negedge clk);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0001_0008, 64'h0000_1122, 5'b00011}) begin
         n_errors++;
         $display("FAIL swx_access2: waddr=%h wdata=%h mask=%b required 00010008/00001122/00011",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      issue(1'b1, 3'b001, 32'h0001_0003, 32'h0000_A1B2, 5'd10, 64'h0, 32'h0, 1'b0, 3, 1'b1);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0001_0000, 64'hB200_0000, 5'b01000}) begin
         n_errors++;
         $display("FAIL shx_access: waddr=%h wdata=%h mask=%b required 00010000/b2000000/01000",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      @(negedge clk);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0001_0004, 64'h0000_00A1, 5'b00001}) begin
         n_errors++;
         $display("FAIL shx_access2: waddr=%h wdata=%h mask=%b required 00010004/000000a1/00001",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      // Odd halfword that stays inside the word: single write.
      issue(1'b1, 3'b001, 32'h0001_0001, 32'h0000_A1B2, 5'd11, 64'h0, 32'h0, 1'b0, 2, 1'b1);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0001_0000, 64'h00A1_B200, 5'b00110}) begin
         n_errors++;
         $display("FAIL sh1_access: waddr=%h wdata=%h mask=%b required 00010000/00a1b200/00110",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      issue(1'b0, 3'b010, 32'h0001_0006, 32'h0, 5'd12, rd64, 32'h6655_4433, 1'b0, 2, 1'b1);
      issue(1'b0, 3'b001, 32'h0001_0001, 32'h0, 5'd13, rd64, 32'h0000_3322, 1'b0, 2, 1'b1);
`else
      issue(1'b1, 3'b010, 32'h0001_0006, 32'h1122_3344, 5'd9, 64'h0, 32'h0, 1'b1, 2, 1'b1);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (DMemWMask_o !== 5'b0) begin
            n_errors++;
            $display("FAIL swx_mask%0d: mask=%b required 00000", i, DMemWMask_o);
         end
         @(negedge clk);
      end
      issue(1'b1, 3'b001, 32'h0001_0003, 32'h0000_A1B2, 5'd10, 64'h0, 32'h0, 1'b1, 2, 1'b1);
      n_checks++;
      if (DMemWMask_o !== 5'b0) begin
         n_errors++;
         $display("FAIL shx_mask: mask=%b required 00000", DMemWMask_o);
      end
      issue(1'b1, 3'b001, 32'h0001_0001, 32'h0000_A1B2, 5'd11, 64'h0, 32'h0, 1'b1, 2, 1'b1);
      issue(1'b0, 3'b010, 32'h0001_0006, 32'h0, 5'd12, rd64, 32'h0, 1'b1, 2, 1'b1);
      issue(1'b0, 3'b001, 32'h0001_0001, 32'h0, 5'd13, rd64, 32'h0, 1'b1, 2, 1'b1);
`endif
      wait_drain("misalign");
   endtask

   task automatic test_illegal();
      logic [63:0] rd64 = 64'h1111_2222_3333_4444;
      issue(1'b0, 3'b011, 32'h0001_0000, 32'h0, 5'd14, rd64, 32'h0, 1'b1, 2, 1'b1);
      issue(1'b0, 3'b110, 32'h0001_0000, 32'h0, 5'd15, rd64, 32'h0, 1'b1, 2, 1'b1);
      issue(1'b0, 3'b111, 32'h0001_0000, 32'h0, 5'd16, rd64, 32'h0, 1'b1, 2, 1'b1);
      issue(1'b1, 3'b100, 32'h0001_0000, 32'hFFFF_FFFF, 5'd17, 64'h0, 32'h0, 1'b1, 2, 1'b1);
      n_checks++;
      if (DMemWMask_o !== 5'b0) begin
         n_errors++;
         $display("FAIL illegal_store_mask: mask=%b required 00000", DMemWMask_o);
      end
      issue(1'b1, 3'b111, 32'h0001_0000, 32'hFFFF_FFFF, 5'd18, 64'h0, 32'h0, 1'b1, 2, 1'b1);
      wait_drain("illegal");
   endtask

   task automatic test_wrap();
`ifdef LSU_MISALIGN_EN
      issue(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_BABE, 5'd19, 64'h0, 32'h0, 1'b0, 3, 1'b1);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'hFFFF_FFFC, 64'hBABE_0000, 5'b01100}) begin
         n_errors++;
         $display("FAIL wrap_access: waddr=%h wdata=%h mask=%b required fffffffc/babe0000/01100",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
      @(negedge clk);
      n_checks++;
      if ({DMemWAddr_o, DMemWData_o, DMemWMask_o} !== {32'h0, 64'h0000_CAFE, 5'b00011}) begin
         n_errors++;
         $display("FAIL wrap_access2: waddr=%h wdata=%h mask=%b required 00000000/0000cafe/00011",
                  DMemWAddr_o, DMemWData_o, DMemWMask_o);
      end
`else
      issue(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 5'd19, 64'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2, 1'b1);
      n_checks++;
      if (DMemRAddr_o !== 32'hFFFF_FFFC) begin
         n_errors++;
         $display("FAIL wrap_raddr: raddr=%h required fffffffc", DMemRAddr_o);
      end
`endif
      wait_drain("wrap");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         logic [63:0] rd64;
         logic [1:0]  off;
         logic [31:0] exp_d;
         logic [63:0] sh;
         rd64 = {$urandom, $urandom};
         off  = 2'($urandom_range(0, 3));
         if (i % 2 == 0) begin
            issue(1'b0, 3'b010, 32'h0002_0000 + 32'(i * 4), 32'h0, 5'(i + 20), rd64,
                  rd64[31:0], 1'b0, 2, 1'b1);
         end else begin
            sh    = rd64 >> (8 * off);
            exp_d = {24'h0, sh[7:0]};
            issue(1'b0, 3'b100, 32'h0002_0000 + {30'h0, off}, 32'h0, 5'(i + 20), rd64,
                  exp_d, 1'b0, 2, 1'b1);
         end
      end
      wait_drain("back_to_back");
   endtask

   task automatic test_reset_mid();
`ifdef LSU_MISALIGN_EN
      issue(1'b1, 3'b010, 32'h0001_0006, 32'h1122_3344, 5'd30, 64'h0, 32'h0, 1'b0, 3, 1'b0);
      @(negedge clk);
      n_checks++;
      if (DMemWMask_o !== 5'b00011) begin
         n_errors++;
         $display("FAIL rst_pre_mask: mask=%b required 00011", DMemWMask_o);
      end
`else
      issue(1'b1, 3'b010, 32'h0001_0004, 32'h1122_3344, 5'd30, 64'h0, 32'h0, 1'b0, 2, 1'b0);
      n_checks++;
      if (DMemWMask_o !== 5'b01111) begin
         n_errors++;
         $display("FAIL rst_pre_mask: mask=%b required 01111", DMemWMask_o);
      end
`endif
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      n_checks++;
      if ({DMemWMask_o, resp_valid_o, req_ready_o} !== {5'b0, 1'b0, 1'b1}) begin
         n_errors++;
         $display("FAIL rst_mid: mask=%b valid=%b ready=%b required 00000/0/1",
                  DMemWMask_o, resp_valid_o, req_ready_o);
      end
      n_checks++;
      if (DMemRAddr_o !== 32'h0) begin
         n_errors++;
         $display("FAIL rst_mid_raddr: raddr=%h required 00000000", DMemRAddr_o);
      end
      // Monitor flags any response that appears after the aborted store.
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_store_aligned();
      test_load_ext();
      test_misalign();
      test_illegal();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      wait_drain("final");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
